// File: rtl/hazard_unit.sv
// hazard_unit
//   Pipeline control for the 5-stage MIPS datapath. This block issues the stalls
//   and flushes that forwarding cannot resolve. It covers load-use hazards,
//   D-cache waits, I-cache misses, taken redirects resolved in EX, and halt.
//   A registered FSM tracks two things: a wrong-path fetch still in flight
//   after a redirect, and a sticky halt.
//
//   Optional feature: define HAZARD_PERF_EN to build the saturating
//   stall/flush performance counters. Without it, both counter ports read 0.
//
// Ports
//   CLK, nRST                       clock (rising edge); async reset, active low
//   id_rs, id_rt, id_usesRt         source operands of the instruction in ID
//   ex_memRead, ex_dest             load flag and destination of the instruction in EX
//   ex_branchTaken                  EX redirects the PC this cycle
//   mem_dREN, mem_dWEN, dhit        MEM data request and its completion
//   ihit                            I-cache returns a fetch this cycle
//   wb_halt                         halt instruction retiring in WB
//   pc_en, *_en                     PC and pipeline-latch enables
//   ifid_flush, idex_flush          latch clears (a clear wins over an enable)
//   exmem_flush                     reserved, always 0
//   hz_state                        00 RUN, 01 DWAIT, 10 FLUSH_PEND, 11 HALTED
//   stall_cycles, flush_count       performance counters
module hazard_unit #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_usesRt,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_branchTaken,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        DWAIT      = 2'b01,
        FLUSH_PEND = 2'b10,
        HALTED     = 2'b11
    } state_e;

    state_e state_q, state_d;
    // Set when a D-cache freeze interrupts FLUSH_PEND. The wrong-path fetch is
    // still owed a discard once the freeze ends.
    logic   pend_q, pend_d;

    logic   dwait;
    logic   load_use;
    logic   fetch_pend;

    assign dwait    = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use = ex_memRead && (ex_dest != '0) &&
                      ((ex_dest == id_rs) || (id_usesRt && (ex_dest == id_rt)));
    assign fetch_pend = (state_q == FLUSH_PEND) || ((state_q == DWAIT) && pend_q);

    assign exmem_flush = 1'b0;
    assign hz_state    = state_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        state_d    = state_q;
        pend_d     = pend_q;

        if (!nRST || state_q == HALTED || wb_halt || dwait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (!nRST) begin
                state_d = RUN;
                pend_d  = 1'b0;
            end else if (state_q == HALTED || wb_halt) begin
                state_d = HALTED;
                pend_d  = 1'b0;
            end else begin
                // Everything is frozen, so EX keeps presenting its redirect.
                // The redirect is therefore taken on the dhit cycle.
                state_d = DWAIT;
                pend_d  = fetch_pend;
            end
        end else begin
            state_d = RUN;
            pend_d  = 1'b0;
            if (ex_branchTaken) begin
                pc_en      = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (!ihit) state_d = FLUSH_PEND;
            end else if (fetch_pend) begin
                // The returning instruction is wrong-path: discard it and hold PC.
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
                if (!ihit) state_d = FLUSH_PEND;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_q, flush_q;
    logic             redirect_acc;

    assign redirect_acc = nRST && (state_q != HALTED) && !wb_halt && !dwait && ex_branchTaken;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((state_q != HALTED) && !pc_en && (stall_q != '1))
                stall_q <= stall_q + CNT_ONE;
            if (redirect_acc && (flush_q != '1))
                flush_q <= flush_q + CNT_ONE;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
